config_chain_loader: RTL and testbench

//  Configures one connection/switch-block config shift chain. Accepts config words on a valid/ready

---
 rtl/fabric_cfg_pkg.sv | 24 ++
 rtl/cfg_serdes.sv | 47 ++++
 rtl/config_chain_loader.sv | 117 +++++++++++
 tb/tb_config_chain_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration chain loaders: the loader
// state encoding and the chain lengths of the tile chains it serves.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    COMMIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Config chain lengths per tile chain type.
  localparam int CB_N_CHAIN_LEN = 330;
  localparam int CB_E_CHAIN_LEN = 330;
  localparam int SB_CHAIN_LEN   = 480;

  // Number of config words needed to cover a chain.
  function automatic int nwords(input int chain_len, input int word);
    return (chain_len + word - 1) / word;
  endfunction

endpackage

// File: rtl/cfg_serdes.sv
// Word-wide serializer/deserializer for one config chain: a PISO feeding
// shift_in LSB-first and a SIPO capturing the displaced chain bits at the
// index of the bit currently being shifted.
module cfg_serdes #(
  parameter int WORD = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [WORD-1:0]         load_data,
  input  logic                    clear,
  input  logic                    shift,
  input  logic [$clog2(WORD)-1:0] idx,
  input  logic                    sin,
  output logic                    sout,
  output logic [WORD-1:0]         par_data
);

  logic [WORD-1:0] wsr;
  logic [WORD-1:0] rsr;

  // Outgoing word: load on accept, then drop one bit per shift cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wsr <= '0;
    end else if (load) begin
      wsr <= load_data;
    end else if (shift) begin
      wsr <= wsr >> 1;
    end
  end

  // Readback word: cleared per word so bits beyond a short final word stay 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsr <= '0;
    end else if (clear) begin
      rsr <= '0;
    end else if (shift) begin
      rsr[idx] <= sin;
    end
  end

  assign sout     = wsr[0];
  assign par_data = rsr;

endmodule

// File: rtl/config_chain_loader.sv
// Loads one tile config shift chain from a word stream, returns the displaced
// chain contents as readback words, and pulses set_in once the whole chain has
// been rewritten. A final word shorter than WORD has its upper bits discarded.
module config_chain_loader
  import fabric_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 330,
  parameter int WORD      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [WORD-1:0] wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [WORD-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            cen,
  output logic            shift_in,
  input  logic            shift_out,
  output logic            set_in
);

  localparam int CNTW = $clog2(CHAIN_LEN + 1);
  localparam int KW   = $clog2(WORD);

  state_t          state;
  logic [CNTW-1:0] bit_cnt;   // chain bits shifted so far in this load
  logic [KW-1:0]   k;         // bit index within the current word
  logic            last;      // current word completes the chain
  logic            accept;
  logic            chain_end;
  logic            word_end;
  logic            ser_bit;

  assign accept    = wr_valid && wr_ready;
  assign chain_end = (bit_cnt == CNTW'(CHAIN_LEN - 1));
  assign word_end  = (k == KW'(WORD - 1));

  // Load sequencing: fetch a word, shift it out, drain readback, repeat, commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      k       <= '0;
      last    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= FETCH;
            bit_cnt <= '0;
            last    <= 1'b0;
          end
        end
        FETCH: begin
          if (accept) begin
            state <= SHIFT;
            k     <= '0;
          end
        end
        SHIFT: begin
          k <= k + 1'b1;
          // Held at CHAIN_LEN-1 rather than wrapping once the chain is full.
          if (!chain_end) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (chain_end) begin
            last  <= 1'b1;
            state <= DRAIN;
          end else if (word_end) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_ready) begin
            state <= last ? COMMIT : FETCH;
          end
        end
        COMMIT: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == FETCH) || (state == SHIFT) ||
                    (state == DRAIN) || (state == COMMIT);
  assign done     = (state == DONE);
  assign wr_ready = (state == FETCH);
  assign rd_valid = (state == DRAIN);
  assign cen      = (state == SHIFT);
  assign set_in   = (state == COMMIT);
  assign shift_in = cen & ser_bit;

  cfg_serdes #(
    .WORD (WORD)
  ) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (wr_data),
    .clear     (accept),
    .shift     (cen),
    .idx       (k),
    .sin       (shift_out),
    .sout      (ser_bit),
    .par_data  (rd_data)
  );

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a physical chain model sits on cen/shift_in/
// shift_out/set_in; a reference model predicts readback words and committed
// chain contents from the word streams; a monitor scoreboards readback.
module tb_config_chain_loader;

  localparam int L     = 10;
  localparam int W     = 4;
  localparam int NW    = (L + W - 1) / W;
  localparam int LASTB = L - W * (NW - 1);

  typedef logic [W-1:0] words_t [NW];

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_valid = 1'b0;
  logic         rd_ready = 1'b0;
  logic         shift_out;
  logic         busy, done, wr_ready, rd_valid, cen, shift_in, set_in;
  logic [W-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] chain = '0;
  logic [L-1:0] committed = '0;
  int           cen_cnt = 0;
  int           set_cnt = 0;
  int           acc_cnt = 0;
  logic [W-1:0] exp_q[$];
  bit           prior[$];   // chain contents in the order they will come out
  bit           hold_rd = 1'b0;
  bit           prev_pend = 1'b0;
  logic [W-1:0] prev_data = '0;
  words_t       w;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(L), .WORD(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .cen       (cen),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .set_in    (set_in)
  );

  // Physical chain: shifts while cen is high, commit latch captures on set_in.
  always @(posedge clk) begin
    if (cen) chain <= {chain[L-2:0], shift_in};
    if (set_in) committed <= chain;
  end
  assign shift_out = chain[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Readback consumer with random backpressure, optionally held off.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rd_ready = hold_rd ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: scoreboard readback, count activity, watch output exclusivity.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_pend = 1'b0;
      end else begin
        if (cen) cen_cnt++;
        if (set_in) set_cnt++;
        if (wr_valid && wr_ready) acc_cnt++;
        check("excl", 64'({cen & set_in, cen & rd_valid, wr_ready & rd_valid}), 64'(0));
        if (prev_pend && rd_valid) check("rd_stable", 64'(rd_data), 64'(prev_data));
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
          else check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
        end
        prev_pend = rd_valid && !rd_ready;
        prev_data = rd_data;
      end
    end
  end

  task automatic load(input words_t wl, input bit greedy, input int rst_at,
                      input bit poke, input bit hold);
    bit           nstream[$];
    logic [W-1:0] e;
    logic [L-1:0] exp_vec;
    logic [W-1:0] d0;
    int           bits;
    int           n;
    nstream = {};
    for (int j = 0; j < NW; j++) begin
      bits = (j == NW - 1) ? LASTB : W;
      e = '0;
      for (int i = 0; i < bits; i++) begin
        e[i] = prior[j * W + i];
        nstream.push_back(wl[j][i]);
      end
      exp_q.push_back(e);
    end
    cen_cnt = 0;
    set_cnt = 0;
    acc_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'({busy, done}), 64'(2'b10));
    for (int j = 0; j < NW; j++) begin
      wr_data  = wl[j];
      wr_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!wr_ready && n < 200);
      if (!wr_ready) begin
        check("wr_ready_timeout", 64'(0), 64'(1));
        wr_valid = 1'b0;
        return;
      end
      tick();
      if (!greedy || j == NW - 1) wr_valid = 1'b0;
      if (hold && j == 0) begin
        hold_rd = 1'b1;
        n = 0;
        while (!rd_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        d0 = rd_data;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          check("drain_hold", 64'({cen, wr_ready, rd_valid, rd_data}), 64'({3'b001, d0}));
        end
        hold_rd = 1'b0;
      end
      if (poke && j == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (rst_at > 0 && j == 1) begin
        repeat (rst_at) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({busy, done, wr_ready, rd_valid, cen, shift_in, set_in}), 64'(0));
        check("rst_mid_rd_data", 64'(rd_data), 64'(0));
        wr_valid = 1'b0;
        repeat (3) tick();
        check("rst_no_set", 64'(set_cnt), 64'(0));
        exp_q.delete();
        prior = {};
        for (int t = 0; t < L; t++) prior.push_back(chain[L-1-t]);
        rst = 1'b1;
        tick();
        return;
      end
    end
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done", 64'({done, busy}), 64'(2'b10));
    check("cen_cycles", 64'(cen_cnt), 64'(L));
    check("set_pulses", 64'(set_cnt), 64'(1));
    check("words_taken", 64'(acc_cnt), 64'(NW));
    check("rd_all_drained", 64'(exp_q.size()), 64'(0));
    for (int t = 0; t < L; t++) exp_vec[L-1-t] = nstream[t];
    check("committed", 64'(committed), 64'(exp_vec));
    prior = nstream;
    tick();
  endtask

  initial begin
    for (int t = 0; t < L; t++) prior.push_back(1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({busy, done, wr_ready, rd_valid, cen, shift_in, set_in}), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    rst = 1'b1;
    tick();

    w = '{4'hF, 4'h0, 4'hE};
    load(w, 1'b0, 0, 1'b0, 1'b0);
    w = '{4'hA, 4'h5, 4'h3};
    load(w, 1'b0, 0, 1'b0, 1'b0);
    for (int j = 0; j < NW; j++) w[j] = W'($urandom);
    load(w, 1'b0, 0, 1'b0, 1'b1);
    for (int j = 0; j < NW; j++) w[j] = W'($urandom);
    load(w, 1'b1, 0, 1'b1, 1'b0);
    for (int j = 0; j < NW; j++) w[j] = W'($urandom);
    load(w, 1'b0, 2, 1'b0, 1'b0);
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < NW; j++) w[j] = W'($urandom);
      load(w, 1'(($urandom_range(0, 1))), 0, 1'(($urandom_range(0, 1))), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
